bitwise_op_responder: RTL and testbench

Sequential responder for the team's bitwise-operator stimulus benches. It accepts operand/opcode requests over a valid/ready handshake and computes AND/OR/XOR/XNOR. Results are queued in a small FIFO and returned over a second valid/ready handshake. It sits between a stimulus initiator and a result checker/monitor.

---
 rtl/bitwise_op_pkg.sv | 38 +++
 rtl/bitwise_op_fifo.sv | 73 +++++++
 rtl/bitwise_op_responder.sv | 86 ++++++++
 tb/tb_bitwise_op_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_op_pkg.sv
// Shared types and the bitwise evaluation function for the bitwise-op responder.
// Used by the RTL and by bench reference models alike.
package bitwise_op_pkg;

  localparam int OP_W   = 2;
  // Evaluation width; callers truncate the result to their operand width.
  localparam int EVAL_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } bitwise_op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  function automatic logic [EVAL_W-1:0] bitwise_op_eval(
    input bitwise_op_e       op,
    input logic [EVAL_W-1:0] a,
    input logic [EVAL_W-1:0] b
  );
    logic [EVAL_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_op_fifo.sv
// Synchronous result FIFO with a registered occupancy state machine.
// full/empty come straight from the state register so the request side
// never sees a combinational path from the pop side.
//
// state       | meaning
// OCC_EMPTY   | count == 0, nothing to present
// OCC_PARTIAL | 0 < count < DEPTH, push and pop both allowed
// OCC_FULL    | count == DEPTH, push blocked until a pop
module bitwise_op_fifo
  import bitwise_op_pkg::*;
#(
  parameter int DW    = 5,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  occ_state_e    state;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] cnt_nxt;

  // Qualify handshakes against the current occupancy and compute next count.
  always_comb begin
    do_push = push && (state != OCC_FULL);
    do_pop  = pop && (state != OCC_EMPTY);
    cnt_nxt = count;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  // Storage, pointers, count and occupancy state advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= OCC_EMPTY;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      if (cnt_nxt == '0)               state <= OCC_EMPTY;
      else if (cnt_nxt == CW'(DEPTH))  state <= OCC_FULL;
      else                             state <= OCC_PARTIAL;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (state == OCC_FULL);
  assign empty = (state == OCC_EMPTY);

endmodule

// File: rtl/bitwise_op_responder.sv
// Bitwise-op responder: accepts op/operand requests, computes the bitwise
// result and returns it through a small in-order FIFO.
// Optional statistics counters are enabled with BITWISE_OP_STATS_EN.
module bitwise_op_responder
  import bitwise_op_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OP_W-1:0]          req_op,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [OP_W-1:0]          rsp_op,
  output logic [$clog2(DEPTH):0]   count
`ifdef BITWISE_OP_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         stat_req,
  output logic [CNT_W-1:0]         stat_rsp
`endif
);

  localparam int DW = WIDTH + OP_W;

  logic [WIDTH-1:0] result;
  logic [DW-1:0]    head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  // Compute the result for the request currently on the bus.
  always_comb begin
    result = WIDTH'(bitwise_op_eval(bitwise_op_e'(req_op),
                                    EVAL_W'(req_a), EVAL_W'(req_b)));
  end

  assign req_ready = !full;
  assign rsp_valid = !empty;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  bitwise_op_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_op, result}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stale storage is never shown once the queue drains.
  assign rsp_data = rsp_valid ? head[WIDTH-1:0]      : '0;
  assign rsp_op   = rsp_valid ? head[DW-1:WIDTH]     : '0;

`ifdef BITWISE_OP_STATS_EN
  // Handshake counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req <= '0;
      stat_rsp <= '0;
    end else if (stat_clr) begin
      stat_req <= '0;
      stat_rsp <= '0;
    end else begin
      if (push) stat_req <= stat_req + CNT_W'(1);
      if (pop)  stat_rsp <= stat_rsp + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_op_responder.sv
// Directed and random checks for bitwise_op_responder (WIDTH=3, DEPTH=2).
// Statistics checks are compiled in with BITWISE_OP_STATS_EN.
module tb_bitwise_op_responder;
  import bitwise_op_pkg::*;

  localparam int WIDTH = 3;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_op;
  logic [1:0]       count;
`ifdef BITWISE_OP_STATS_EN
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] stat_req;
  logic [CNT_W-1:0] stat_rsp;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bitwise_op_responder #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .count     (count)
`ifdef BITWISE_OP_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_req  (stat_req),
    .stat_rsp  (stat_rsp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_e;
    logic [4:0] got_e;
    logic [4:0] exp_q[$];
    logic       push_m;
    logic       pop_m;
    int         sent;
    int         recv;
    int         cyc;

    // Reset with a request driven: must be ignored.
    send(2'd0, 3'b111, 3'b111);
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_op", 32'(rsp_op), 32'd0);
`ifdef BITWISE_OP_STATS_EN
    chk("rst_stat_req", 32'(stat_req), 32'd0);
    chk("rst_stat_rsp", 32'(stat_rsp), 32'd0);
`endif
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // XNOR latency and masking.
    rsp_ready = 1'b1;
    send(2'd3, 3'b001, 3'b111);
    tick();
    chk("xnor1_valid", 32'(rsp_valid), 32'd1);
    chk("xnor1_data", 32'(rsp_data), 32'b001);
    chk("xnor1_op", 32'(rsp_op), 32'd3);
    send(2'd3, 3'b000, 3'b111);
    tick();
    chk("xnor2_count", 32'(count), 32'd1);
    chk("xnor2_data", 32'(rsp_data), 32'b000);
    req_valid = 1'b0;
    tick();
    chk("xnor_drain", 32'(count), 32'd0);

    // Back-to-back, one result per cycle.
    send(2'd0, 3'b111, 3'b111);
    tick();
    chk("b2b_and_data", 32'(rsp_data), 32'b111);
    chk("b2b_and_op", 32'(rsp_op), 32'd0);
    send(2'd1, 3'b000, 3'b001);
    tick();
    chk("b2b_or_data", 32'(rsp_data), 32'b001);
    chk("b2b_or_op", 32'(rsp_op), 32'd1);
    send(2'd2, 3'b101, 3'b011);
    tick();
    chk("b2b_xor_data", 32'(rsp_data), 32'b110);
    chk("b2b_xor_op", 32'(rsp_op), 32'd2);
    chk("b2b_count", 32'(count), 32'd1);
    req_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(count), 32'd0);

    // Backpressure: fill, hold a third request, then release.
    rsp_ready = 1'b0;
    send(2'd1, 3'b010, 3'b100);
    tick();
    send(2'd0, 3'b110, 3'b011);
    tick();
    chk("bp_full_count", 32'(count), 32'd2);
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_head_data", 32'(rsp_data), 32'b110);
    chk("bp_head_op", 32'(rsp_op), 32'd1);
    send(2'd2, 3'b111, 3'b001);
    tick();
    chk("bp_hold_count", 32'(count), 32'd2);
    chk("bp_hold_data", 32'(rsp_data), 32'b110);
    rsp_ready = 1'b1;
    tick();
    chk("bp_pop1_count", 32'(count), 32'd1);
    chk("bp_pop1_data", 32'(rsp_data), 32'b010);
    chk("bp_pop1_op", 32'(rsp_op), 32'd0);
    chk("bp_pop1_ready", 32'(req_ready), 32'd1);
    tick();
    chk("bp_third_count", 32'(count), 32'd1);
    chk("bp_third_data", 32'(rsp_data), 32'b110);
    chk("bp_third_op", 32'(rsp_op), 32'd2);
    req_valid = 1'b0;
    tick();
    chk("bp_drain_count", 32'(count), 32'd0);
    chk("bp_drain_valid", 32'(rsp_valid), 32'd0);

    // Reset with two entries queued.
    rsp_ready = 1'b0;
    send(2'd0, 3'b111, 3'b101);
    tick();
    send(2'd1, 3'b001, 3'b010);
    tick();
    req_valid = 1'b0;
    chk("mid_pre_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    send(2'd2, 3'b101, 3'b010);
    @(posedge clk);
    #1;
    chk("mid_rst_ignore", 32'(count), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("mid_post_count", 32'(count), 32'd0);

`ifdef BITWISE_OP_STATS_EN
    // Statistics: 5 requests, 3 pops, then clear racing a pop.
    stat_clr = 1'b1;
    tick();
    stat_clr  = 1'b0;
    rsp_ready = 1'b1;
    send(2'd0, 3'b001, 3'b011);
    tick();
    send(2'd1, 3'b001, 3'b011);
    tick();
    send(2'd2, 3'b001, 3'b011);
    tick();
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    send(2'd3, 3'b001, 3'b011);
    tick();
    send(2'd0, 3'b100, 3'b110);
    tick();
    req_valid = 1'b0;
    chk("stat_req5", 32'(stat_req), 32'd5);
    chk("stat_rsp3", 32'(stat_rsp), 32'd3);
    rsp_ready = 1'b1;
    stat_clr  = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr_req", 32'(stat_req), 32'd0);
    chk("stat_clr_rsp", 32'(stat_rsp), 32'd0);
    chk("stat_clr_count", 32'(count), 32'd1);
    tick();
    chk("stat_drain", 32'(count), 32'd0);
`endif

    // Random stream: continuous requests, rsp_ready toggling each cycle.
    sent      = 0;
    recv      = 0;
    cyc       = 0;
    rsp_ready = 1'b1;
    send(2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)));
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 6000) begin
      chk("rnd_count", 32'(count), 32'(exp_q.size()));
      chk("rnd_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      chk("rnd_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      pop_m  = rsp_ready && (exp_q.size() != 0);
      push_m = req_valid && (exp_q.size() < DEPTH);
      if (pop_m) begin
        exp_e = exp_q.pop_front();
        got_e = {rsp_op, rsp_data};
        chk("rnd_data", 32'(got_e), 32'(exp_e));
        recv++;
      end
      if (push_m) begin
        exp_e = {req_op, WIDTH'(bitwise_op_eval(bitwise_op_e'(req_op),
                                                EVAL_W'(req_a), EVAL_W'(req_b)))};
        exp_q.push_back(exp_e);
        sent++;
      end
      tick();
      cyc++;
      rsp_ready = ~rsp_ready;
      if (push_m) begin
        if (sent < 1000)
          send(2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)));
        else
          req_valid = 1'b0;
      end
    end
    chk("rnd_sent", 32'(sent), 32'd1000);
    chk("rnd_recv", 32'(recv), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
